// File: rtl/fetch_queue_n.sv
// Instruction-fetch front end: line-aligned fetch requests feed a circular queue of
// PC-tagged instructions presented in order to decode; redirects flush and re-steer.
module fetch_queue_n #(
   parameter int XLEN        = 32,
   parameter int FETCH_WIDTH = 2,
   parameter int LINE_INSTS  = 2,
   parameter int DEPTH       = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               redirect_valid_i,
   input  logic [XLEN-1:0]                    redirect_pc_i,
   input  logic [$clog2(FETCH_WIDTH+1)-1:0]   consume_cnt_i,
   output logic                               mem_req_valid_o,
   output logic [XLEN-1:0]                    mem_req_addr_o,
   input  logic                               mem_req_ready_i,
   input  logic                               mem_resp_valid_i,
   input  logic [32*LINE_INSTS-1:0]           mem_resp_data_i,
   output logic [FETCH_WIDTH-1:0]             out_valid_o,
   output logic [FETCH_WIDTH*32-1:0]          out_inst_o,
   output logic [FETCH_WIDTH*XLEN-1:0]        out_pc_o,
   output logic [FETCH_WIDTH*XLEN-1:0]        out_npc_o,
   output logic [$clog2(DEPTH+1)-1:0]         count_o
);

   localparam int LINE_BYTES = LINE_INSTS * 4;
   localparam int PW         = $clog2(DEPTH);
   localparam int CW         = $clog2(DEPTH + 1);
   localparam int NW         = $clog2(FETCH_WIDTH + 1);
   localparam int SW         = (LINE_INSTS > 1) ? $clog2(LINE_INSTS) : 1;

   logic [31:0]      r_inst [DEPTH];
   logic [XLEN-1:0]  r_pc   [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic [XLEN-1:0]  r_fetch_pc;
   logic [SW-1:0]    r_skip;
   logic             r_outstanding;
   logic             r_epoch;
   logic             r_req_epoch;

   logic [XLEN-1:0]  w_line_addr;
   logic             w_space_ok;
   logic             w_req_valid;
   logic             w_fire;
   logic             w_resp;
   logic             w_write;
   logic [CW-1:0]    w_nwritten;
   logic [CW-1:0]    w_consumed;
   logic [SW-1:0]    w_redir_skip;
   logic [NW-1:0]    w_avail;
   logic [PW-1:0]    w_wr_idx [LINE_INSTS];
   logic             w_wr_en  [LINE_INSTS];
   logic [PW-1:0]    w_rd_idx [FETCH_WIDTH];

   assign w_line_addr  = r_fetch_pc & ~XLEN'(LINE_BYTES - 1);
   // Space check uses registered count only, so a same-cycle consume never enables a request.
   assign w_space_ok   = (DEPTH - int'(r_count)) >= LINE_INSTS;
   assign w_req_valid  = !reset && !r_outstanding && !redirect_valid_i && w_space_ok;
   assign w_fire       = w_req_valid && mem_req_ready_i;
   assign w_resp       = mem_resp_valid_i && r_outstanding;
   assign w_write      = !reset && w_resp && (r_req_epoch == r_epoch) && !redirect_valid_i;
   assign w_nwritten   = CW'(LINE_INSTS) - CW'(r_skip);
   assign w_consumed   = CW'(consume_cnt_i);
   assign w_redir_skip = (LINE_INSTS > 1) ? SW'(redirect_pc_i >> 2) : '0;
   assign w_avail      = (r_count >= CW'(FETCH_WIDTH)) ? NW'(FETCH_WIDTH) : NW'(r_count);

   assign mem_req_valid_o = w_req_valid;
   assign mem_req_addr_o  = w_line_addr;
   assign count_o         = r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_fetch_pc    <= '0;
         r_skip        <= '0;
         r_outstanding <= 1'b0;
         r_epoch       <= 1'b0;
         r_req_epoch   <= 1'b0;
      end else begin
         if (w_fire) begin
            r_outstanding <= 1'b1;
            r_req_epoch   <= r_epoch;
         end else if (w_resp) begin
            r_outstanding <= 1'b0;
         end

         if (redirect_valid_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_epoch    <= ~r_epoch;
            r_fetch_pc <= redirect_pc_i;
            r_skip     <= w_redir_skip;
         end else begin
            r_head <= r_head + PW'(consume_cnt_i);
            if (w_write) begin
               r_tail     <= r_tail + PW'(w_nwritten);
               r_count    <= r_count + w_nwritten - w_consumed;
               r_fetch_pc <= r_fetch_pc + XLEN'(LINE_BYTES);
               r_skip     <= '0;
            end else begin
               r_count <= r_count - w_consumed;
            end
         end
      end
   end

   // Instruction k of the line lands at tail + (k - skip); slots below skip are not written.
   always_comb begin
      for (int unsigned k = 0; k < LINE_INSTS; k++) begin
         w_wr_idx[k] = r_tail + PW'(k) - PW'(r_skip);
         w_wr_en[k]  = w_write && (SW'(k) >= r_skip);
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < LINE_INSTS; k++) begin
         if (w_wr_en[k]) begin
            r_inst[w_wr_idx[k]] <= mem_resp_data_i[32*k +: 32];
            r_pc[w_wr_idx[k]]   <= w_line_addr + XLEN'(4 * k);
         end
      end
   end

   always_comb begin
      out_valid_o = '0;
      out_inst_o  = '0;
      out_pc_o    = '0;
      out_npc_o   = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         w_rd_idx[i]                = r_head + PW'(i);
         out_valid_o[i]             = r_count > CW'(i);
         out_inst_o[32*i +: 32]     = r_inst[w_rd_idx[i]];
         out_pc_o[XLEN*i +: XLEN]   = r_pc[w_rd_idx[i]];
         out_npc_o[XLEN*i +: XLEN]  = r_pc[w_rd_idx[i]] + XLEN'(4);
      end
   end

   a_consume_le_valid: assert property (@(posedge clk) disable iff (reset)
      consume_cnt_i <= w_avail);

endmodule

// File: tb/tb_fetch_queue_n.sv
// Directed bench for fetch_queue_n: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_fetch_queue_n;
   localparam int XLEN  = 32;
   localparam int FW    = 2;
   localparam int LI    = 2;
   localparam int DEPTH = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              redirect_valid_i;
   logic [XLEN-1:0]   redirect_pc_i;
   logic [1:0]        consume_cnt_i;
   logic              mem_req_valid_o;
   logic [XLEN-1:0]   mem_req_addr_o;
   logic              mem_req_ready_i;
   logic              mem_resp_valid_i;
   logic [32*LI-1:0]  mem_resp_data_i;
   logic [FW-1:0]     out_valid_o;
   logic [FW*32-1:0]  out_inst_o;
   logic [FW*XLEN-1:0] out_pc_o;
   logic [FW*XLEN-1:0] out_npc_o;
   logic [4:0]        count_o;

   always #5 clk = ~clk;

   fetch_queue_n #(.XLEN(XLEN), .FETCH_WIDTH(FW), .LINE_INSTS(LI), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
      .consume_cnt_i(consume_cnt_i),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
      .mem_req_ready_i(mem_req_ready_i),
      .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
      .out_valid_o(out_valid_o), .out_inst_o(out_inst_o), .out_pc_o(out_pc_o),
      .out_npc_o(out_npc_o), .count_o(count_o)
   );

   int errors = 0;
   int checks = 0;

   // memory responder state
   int              lat = 1;
   bit              resp_en = 1'b1;
   bit              pend = 1'b0;
   int              pend_cnt = 0;
   logic [XLEN-1:0] pend_addr = '0;
   bit              last_fire = 1'b0;
   logic [XLEN-1:0] fire_log[$];

   // reference model: instruction queue plus fetch bookkeeping
   logic [31:0]     mq_pc[$];
   logic [31:0]     mq_inst[$];
   logic [XLEN-1:0] m_fpc = '0;
   int              m_skip = 0;
   bit              m_out = 1'b0;
   bit              m_stale = 1'b0;

   function automatic logic [31:0] memword(input logic [31:0] pc);
      if (pc == 32'h0) return 32'h1111_1111;
      if (pc == 32'h4) return 32'h2222_2222;
      return {16'hC0DE, pc[15:0]};
   endfunction

   function automatic logic [63:0] line_data(input logic [31:0] a);
      return {memword(a + 32'd4), memword(a)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_reqv();
      return !reset && !m_out && !redirect_valid_i && ((DEPTH - mq_pc.size()) >= LI);
   endfunction

   task automatic compare();
      int n;
      logic [FW-1:0] ev;
      bit mv;
      n  = mq_pc.size();
      mv = model_reqv();
      chk("req_valid", mem_req_valid_o, mv);
      if (mv) chk("req_addr", mem_req_addr_o, m_fpc & ~32'h7);
      chk("count", count_o, 64'(n));
      for (int i = 0; i < FW; i++) ev[i] = (i < n);
      chk("out_valid", out_valid_o, ev);
      for (int i = 0; i < FW; i++) begin
         if (i < n) begin
            chk("lane_inst", out_inst_o[32*i +: 32], mq_inst[i]);
            chk("lane_pc", out_pc_o[XLEN*i +: XLEN], mq_pc[i]);
            chk("lane_npc", out_npc_o[XLEN*i +: XLEN], mq_pc[i] + 32'd4);
         end
      end
   endtask

   task automatic model_update();
      bit mfire;
      bit resp;
      logic [31:0] la;
      mfire = model_reqv() && mem_req_ready_i;
      resp  = mem_resp_valid_i && m_out;
      if (reset) begin
         mq_pc.delete(); mq_inst.delete();
         m_fpc = '0; m_skip = 0; m_out = 0; m_stale = 0;
      end else if (redirect_valid_i) begin
         mq_pc.delete(); mq_inst.delete();
         if (resp) m_out = 0;
         else if (m_out) m_stale = 1;
         m_fpc  = redirect_pc_i;
         m_skip = int'(redirect_pc_i[2]);
      end else begin
         for (int c = 0; c < int'(consume_cnt_i); c++) begin
            if (mq_pc.size() > 0) begin
               void'(mq_pc.pop_front());
               void'(mq_inst.pop_front());
            end
         end
         if (resp) begin
            m_out = 0;
            if (!m_stale) begin
               la = m_fpc & ~32'h7;
               for (int k = m_skip; k < LI; k++) begin
                  mq_pc.push_back(la + 32'(4 * k));
                  mq_inst.push_back(mem_resp_data_i[32*k +: 32]);
               end
               m_fpc  = m_fpc + 32'd8;
               m_skip = 0;
            end
         end
         if (mfire) begin
            m_out   = 1;
            m_stale = 0;
         end
      end
   endtask

   task automatic settle();
      mem_resp_valid_i = 1'b0;
      mem_resp_data_i  = '0;
      if (pend && pend_cnt == 0 && resp_en) begin
         mem_resp_valid_i = 1'b1;
         mem_resp_data_i  = line_data(pend_addr);
      end
      @(negedge clk);
   endtask

   task automatic finish_cycle();
      bit dfire;
      if (!reset) compare();
      else chk("req_valid_in_reset", mem_req_valid_o, 1'b0);
      dfire = mem_req_valid_o && mem_req_ready_i;
      if (mem_resp_valid_i) pend = 0;
      else if (pend && pend_cnt > 0) pend_cnt--;
      if (dfire) begin
         pend      = 1;
         pend_addr = mem_req_addr_o;
         pend_cnt  = lat - 1;
         fire_log.push_back(mem_req_addr_o);
      end
      last_fire = dfire;
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      settle();
      finish_cycle();
   endtask

   task automatic pick_consume(input int i);
      int n;
      n = mq_pc.size();
      if (i % 3 == 0) consume_cnt_i = 2'd0;
      else consume_cnt_i = 2'((n >= 2) ? 2 : n);
   endtask

   initial begin
      reset = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0; consume_cnt_i = '0;
      mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
      repeat (3) tick();

      // cold start
      reset = 1'b0;
      settle();
      chk("cold_req_valid", mem_req_valid_o, 1'b1);
      chk("cold_req_addr", mem_req_addr_o, 32'h0);
      chk("cold_count", count_o, 5'd0);
      finish_cycle();
      settle();
      chk("cold_resp_cycle_valid", mem_req_valid_o, 1'b0);
      finish_cycle();
      settle();
      chk("cold_count2", count_o, 5'd2);
      chk("cold_lane0_inst", out_inst_o[31:0], 32'h1111_1111);
      chk("cold_lane1_inst", out_inst_o[63:32], 32'h2222_2222);
      chk("cold_lane0_pc", out_pc_o[31:0], 32'h0);
      chk("cold_lane1_pc", out_pc_o[63:32], 32'h4);
      chk("cold_lane1_npc", out_npc_o[63:32], 32'h8);
      chk("cold_next_addr", mem_req_addr_o, 32'h8);
      finish_cycle();

      // fill to full with no consume
      for (int i = 0; i < 40 && mq_pc.size() < DEPTH; i++) tick();
      settle();
      chk("full_count", count_o, 5'd16);
      chk("full_no_req", mem_req_valid_o, 1'b0);
      finish_cycle();
      repeat (3) tick();
      consume_cnt_i = 2'd2;
      tick();
      consume_cnt_i = 2'd0;
      settle();
      chk("after_consume_count", count_o, 5'd14);
      chk("after_consume_req", mem_req_valid_o, 1'b1);
      chk("after_consume_addr", mem_req_addr_o, 32'h40);
      finish_cycle();

      // pointer wrap with mixed consume
      for (int i = 0; i < 40; i++) begin
         pick_consume(i);
         tick();
      end
      consume_cnt_i = 2'd0;

      // mid-line redirect
      redirect_valid_i = 1'b1; redirect_pc_i = 32'h104;
      settle();
      chk("redir_no_req", mem_req_valid_o, 1'b0);
      finish_cycle();
      redirect_valid_i = 1'b0;
      fire_log.delete();
      settle();
      chk("redir_next_outvalid", out_valid_o, 2'b00);
      chk("redir_next_count", count_o, 5'd0);
      finish_cycle();
      for (int i = 0; i < 20 && mq_pc.size() == 0; i++) tick();
      settle();
      chk("midline_first_addr", (fire_log.size() > 0) ? fire_log[0] : 32'hFFFF_FFFF, 32'h100);
      chk("midline_count", count_o, 5'd1);
      chk("midline_outvalid", out_valid_o, 2'b01);
      chk("midline_pc", out_pc_o[31:0], 32'h104);
      chk("midline_npc", out_npc_o[31:0], 32'h108);
      chk("midline_inst", out_inst_o[31:0], memword(32'h104));
      chk("midline_next_addr", mem_req_addr_o, 32'h108);
      finish_cycle();
      for (int i = 0; i < 40 && mq_pc.size() < 15; i++) tick();
      settle();
      chk("c15_count", count_o, 5'd15);
      chk("c15_no_req", mem_req_valid_o, 1'b0);
      finish_cycle();
      repeat (2) tick();

      // stale response dropped after redirect
      redirect_valid_i = 1'b1; redirect_pc_i = 32'h8;
      resp_en = 1'b0;
      tick();
      redirect_valid_i = 1'b0;
      settle();
      chk("stale_req_addr", mem_req_addr_o, 32'h8);
      chk("stale_req_valid", mem_req_valid_o, 1'b1);
      finish_cycle();
      redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
      tick();
      redirect_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("stale_wait_no_req", mem_req_valid_o, 1'b0);
         finish_cycle();
      end
      resp_en = 1'b1;
      settle();
      chk("stale_resp_count", count_o, 5'd0);
      finish_cycle();

      // backpressure
      mem_req_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("bp_valid", mem_req_valid_o, 1'b1);
         chk("bp_addr", mem_req_addr_o, 32'h200);
         chk("bp_count", count_o, 5'd0);
         finish_cycle();
      end
      mem_req_ready_i = 1'b1;
      fire_log.delete();
      settle();
      chk("bp_accept_addr", mem_req_addr_o, 32'h200);
      finish_cycle();
      settle();
      chk("bp_single_req", mem_req_valid_o, 1'b0);
      chk("bp_fire_count", fire_log.size(), 1);
      finish_cycle();
      settle();
      chk("bp_count2", count_o, 5'd2);
      chk("bp_lane0_pc", out_pc_o[31:0], 32'h200);
      chk("bp_next_addr", mem_req_addr_o, 32'h208);
      finish_cycle();

      // response + consume + redirect in the same cycle
      consume_cnt_i = 2'd2; redirect_valid_i = 1'b1; redirect_pc_i = 32'h300;
      tick();
      consume_cnt_i = 2'd0; redirect_valid_i = 1'b0;
      settle();
      chk("simul_count", count_o, 5'd0);
      chk("simul_outvalid", out_valid_o, 2'b00);
      chk("simul_req_addr", mem_req_addr_o, 32'h300);
      finish_cycle();
      tick();
      settle();
      chk("simul_newepoch_count", count_o, 5'd2);
      chk("simul_newepoch_pc", out_pc_o[31:0], 32'h300);
      finish_cycle();

      // longer memory latency with mixed consume
      lat = 3;
      for (int i = 0; i < 30; i++) begin
         pick_consume(i);
         tick();
      end
      consume_cnt_i = 2'd0;

      // reset mid-flight; the response lands the cycle after reset and is ignored
      lat = 2;
      for (int i = 0; i < 20 && !last_fire; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_req_ready_i = 1'b0;
      repeat (3) tick();
      settle();
      chk("reset_mid_count", count_o, 5'd0);
      chk("reset_mid_req_addr", mem_req_addr_o, 32'h0);
      finish_cycle();
      mem_req_ready_i = 1'b1;
      repeat (10) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
